// File: rtl/flex_sensor_mmio_if.sv
// Processor dmem-side bus for the flex sensor register window.
// The master is the processor; the slave is the peripheral.
interface flex_sensor_mmio_if;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_io;
  logic        hit;
  logic        irq;

  modport master (
    output address_dmem, data, wren,
    input  q_io, hit, irq
  );

  modport slave (
    input  address_dmem, data, wren,
    output q_io, hit, irq
  );
endinterface

// File: rtl/flex_sensor_mmio.sv
// Glove flex sensor input peripheral.
// Each raw line is synchronized and debounced. Channel 0 is right, channel 1 is left.
// Press/release events set sticky flags and bump per-glove press counters.
// All of this is exposed as a four-word register window on the dmem bus.
module flex_sensor_mmio #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [11:0] BASE_ADDR       = 12'hF00,
  parameter int          CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flex_right_raw,
  input  logic              flex_left_raw,
  flex_sensor_mmio_if.slave bus
);

  // dcnt only ever holds 0 .. DEBOUNCE_CYCLES-1
  localparam int             DW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_MASK   = 2'd3;

  logic [1:0]       raw_s;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       stable_q, stable_d;
  logic [DW-1:0]    dcnt_q [2];
  logic [DW-1:0]    dcnt_d [2];
  logic [1:0]       press_s, release_s;
  // flags: [0] right press, [1] left press, [2] right release, [3] left release
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             irq_q, irq_d;
  logic             hit_s, wr_s;
  logic [1:0]       off_s;
  logic [3:0]       w1c_s;
  logic [31:0]      rdata_s;
  logic             unused_data_s;

  assign raw_s         = {flex_left_raw, flex_right_raw};
  assign hit_s         = (bus.address_dmem[11:2] == BASE_ADDR[11:2]);
  assign wr_s          = bus.wren & hit_s;
  assign off_s         = bus.address_dmem[1:0];
  assign unused_data_s = ^{bus.data[31:6], bus.data[1:0]};

  // Two-stage synchronizer and per-channel debounce qualification
  always_comb begin
    s1_d      = raw_s;
    s2_d      = s1_q;
    stable_d  = stable_q;
    press_s   = 2'b00;
    release_s = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      dcnt_d[ch] = '0;
      if (s2_q[ch] != stable_q[ch]) begin
        if (dcnt_q[ch] == DCNT_LAST) begin
          stable_d[ch] = s2_q[ch];
          dcnt_d[ch]   = '0;
        end else begin
          dcnt_d[ch] = dcnt_q[ch] + DW'(1);
        end
      end else begin
        dcnt_d[ch] = '0;
      end
    end
    press_s   = stable_d & ~stable_q;
    release_s = ~stable_d & stable_q;
  end

  // Sticky flags, press counters, mask and irq next state (events win over clears)
  always_comb begin
    flags_d = flags_q;
    mask_d  = mask_q;
    irq_d   = |(flags_q & mask_q);
    if (wr_s && (off_s == OFF_STATUS)) begin
      w1c_s = bus.data[5:2];
    end else begin
      w1c_s = 4'b0000;
    end
    flags_d = (flags_q & ~w1c_s) | {release_s[1], release_s[0], press_s[1], press_s[0]};
    for (int ch = 0; ch < 2; ch++) begin
      if (wr_s && (off_s == 2'(ch + 1))) begin
        cnt_d[ch] = CNT_W'(press_s[ch]);
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(press_s[ch]);
      end
    end
    if (wr_s && (off_s == OFF_MASK)) begin
      mask_d = bus.data[5:2];
    end else begin
      mask_d = mask_q;
    end
  end

  // State register for the whole peripheral
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q      <= 2'b00;
      s2_q      <= 2'b00;
      stable_q  <= 2'b00;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
      flags_q   <= 4'b0000;
      mask_q    <= 4'b0000;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      irq_q     <= irq_d;
    end
  end

  // Read mux: combinational from registered state so the processor can sample it this cycle
  always_comb begin
    rdata_s = 32'd0;
    if (hit_s) begin
      case (off_s)
        2'd0:    rdata_s = {26'd0, flags_q, stable_q};
        2'd1:    rdata_s = 32'(cnt_q[0]);
        2'd2:    rdata_s = 32'(cnt_q[1]);
        2'd3:    rdata_s = {26'd0, mask_q, 2'd0};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.q_io = rdata_s;
  assign bus.hit  = hit_s;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_flex_sensor_mmio.sv
// Self-checking bench for flex_sensor_mmio: directed scenarios followed by
// randomized traffic, all compared against a sample-history reference model.
module tb_flex_sensor_mmio;
  localparam int          DB   = 4;
  localparam int          CW   = 4;
  localparam logic [11:0] BASE = 12'hF00;
  localparam logic [11:0] IDLE = 12'h100;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic r_raw = 1'b0;
  logic l_raw = 1'b0;

  flex_sensor_mmio_if bus();

  flex_sensor_mmio #(.DEBOUNCE_CYCLES(DB), .BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clock          (clock),
    .reset          (reset),
    .flex_right_raw (r_raw),
    .flex_left_raw  (l_raw),
    .bus            (bus)
  );

  // 50 MHz clock
  always #10 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw sample history per glove, bit0 = sample taken at the latest edge
  logic [15:0] hist [2];
  logic [1:0]  m_stable;
  logic [5:0]  m_sticky;   // status image bits [5:2]
  logic [5:0]  m_mask;     // mask image bits [5:2]
  int          m_cnt [2];
  logic        m_irq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hit(input logic [11:0] a);
    return (int'(a) / 4) == (int'(BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (m_hit(a)) begin
      case (a[1:0])
        2'd0:    v = 32'(m_sticky) | 32'(m_stable);
        2'd1:    v = 32'(m_cnt[0]);
        2'd2:    v = 32'(m_cnt[1]);
        default: v = 32'(m_mask);
      endcase
    end
    return v;
  endfunction

  task automatic m_reset();
    hist[0]  = 16'd0;
    hist[1]  = 16'd0;
    m_stable = 2'b00;
    m_sticky = 6'd0;
    m_mask   = 6'd0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_irq    = 1'b0;
  endtask

  // One rising edge of the model with the given bus write
  task automatic m_edge(input logic [11:0] a, input logic [31:0] d, input logic w);
    logic [5:0] old_sticky;
    logic [5:0] old_mask;
    logic       all1, all0;
    old_sticky = m_sticky;
    old_mask   = m_mask;
    hist[0] = {hist[0][14:0], r_raw};
    hist[1] = {hist[1][14:0], l_raw};
    if (w && m_hit(a)) begin
      case (a[1:0])
        2'd0:    m_sticky = m_sticky & ~(d[5:0] & 6'b111100);
        2'd1:    m_cnt[0] = 0;
        2'd2:    m_cnt[1] = 0;
        default: m_mask = d[5:0] & 6'b111100;
      endcase
    end
    for (int ch = 0; ch < 2; ch++) begin
      // the synchronized level seen at this edge is the raw sample from two edges ago;
      // a change is accepted once DB such consecutive samples all disagree with stable
      all1 = 1'b1;
      all0 = 1'b1;
      for (int i = 2; i < DB + 2; i++) begin
        if (hist[ch][i]) all0 = 1'b0;
        else             all1 = 1'b0;
      end
      if (all1 && !m_stable[ch]) begin
        m_stable[ch]     = 1'b1;
        m_sticky[2 + ch] = 1'b1;
        m_cnt[ch]        = (m_cnt[ch] + 1) % (1 << CW);
      end else if (all0 && m_stable[ch]) begin
        m_stable[ch]     = 1'b0;
        m_sticky[4 + ch] = 1'b1;
      end
    end
    m_irq = |(old_sticky & old_mask);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    bus.address_dmem = a;
    #1;
    v = bus.q_io;
  endtask

  task automatic check_all();
    logic [31:0] v;
    logic [11:0] a;
    for (int i = 0; i < 4; i++) begin
      a = BASE + 12'(i);
      rd(a, v);
      check_eq($sformatf("rd_%03h", a), v, m_read(a));
      check_eq($sformatf("hit_%03h", a), 32'(bus.hit), 32'd1);
    end
    a = 12'($urandom_range(0, 12'hEFF));
    rd(a, v);
    check_eq($sformatf("rd_out_%03h", a), v, 32'd0);
    check_eq($sformatf("hit_out_%03h", a), 32'(bus.hit), 32'd0);
    check_eq("irq", 32'(bus.irq), 32'(m_irq));
  endtask

  task automatic tick(input logic r, input logic l, input logic [11:0] a,
                      input logic [31:0] d, input logic w);
    r_raw            = r;
    l_raw            = l;
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = w;
    m_edge(a, d, w);
    @(posedge clock);
    #1;
    bus.wren = 1'b0;
    check_all();
  endtask

  task automatic idle(input logic r, input logic l, input int n);
    for (int i = 0; i < n; i++) tick(r, l, IDLE, 32'd0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    m_reset();
    #1;
    check_all();
    repeat (n) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [31:0] v;
  logic        rr, ll;

  initial begin
    bus.address_dmem = IDLE;
    bus.data         = 32'd0;
    bus.wren         = 1'b0;

    // reset and idle
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 12'(i), v);
      check_eq("reset_reg", v, 32'd0);
    end
    check_eq("reset_irq", 32'(bus.irq), 32'd0);
    rd(12'h100, v);
    check_eq("idle_q_io", v, 32'd0);
    check_eq("idle_hit", 32'(bus.hit), 32'd0);

    // clean right press: accepted on the sixth edge counting the sampling edge
    idle(1'b1, 1'b0, 5);
    rd(BASE, v);
    check_eq("press_not_yet", v, 32'd0);
    idle(1'b1, 1'b0, 1);
    rd(BASE, v);
    check_eq("press_status", v, 32'h5);
    rd(BASE + 12'd1, v);
    check_eq("press_rcount", v, 32'd1);
    rd(BASE + 12'd2, v);
    check_eq("press_lcount", v, 32'd0);

    // release, then clear all sticky flags
    idle(1'b0, 1'b0, 6);
    rd(BASE, v);
    check_eq("release_status", v, 32'h14);
    tick(1'b0, 1'b0, BASE, 32'h3C, 1'b1);
    rd(BASE, v);
    check_eq("w1c_all", v, 32'd0);

    // glitch rejection: three high cycles never qualify
    idle(1'b1, 1'b0, 3);
    idle(1'b0, 1'b0, 8);
    rd(BASE, v);
    check_eq("glitch_status", v, 32'd0);
    rd(BASE + 12'd1, v);
    check_eq("glitch_rcount", v, 32'd1);
    idle(1'b1, 1'b0, 6);
    rd(BASE + 12'd1, v);
    check_eq("held_rcount", v, 32'd2);

    // W1C racing a fresh press: the set wins
    idle(1'b0, 1'b0, 6);
    idle(1'b1, 1'b0, 5);
    tick(1'b1, 1'b0, BASE, 32'h4, 1'b1);
    rd(BASE, v);
    check_eq("w1c_race_bit2", v & 32'h4, 32'h4);
    tick(1'b1, 1'b0, BASE, 32'h4, 1'b1);
    rd(BASE, v);
    check_eq("w1c_later_bit2", v & 32'h4, 32'h0);

    // left counter wrap at 2^CW, then clear racing a press
    tick(1'b1, 1'b0, BASE + 12'd2, 32'hFFFF_FFFF, 1'b1);
    for (int p = 0; p < 17; p++) begin
      idle(1'b1, 1'b1, 6);
      idle(1'b1, 1'b0, 6);
    end
    rd(BASE + 12'd2, v);
    check_eq("wrap_lcount", v, 32'd1);
    idle(1'b1, 1'b1, 5);
    tick(1'b1, 1'b1, BASE + 12'd2, 32'd0, 1'b1);
    rd(BASE + 12'd2, v);
    check_eq("clear_race_lcount", v, 32'd1);

    // irq through the left-press mask
    idle(1'b1, 1'b0, 6);
    tick(1'b1, 1'b0, BASE, 32'h3C, 1'b1);
    tick(1'b1, 1'b0, BASE + 12'd3, 32'h8, 1'b1);
    rd(BASE + 12'd3, v);
    check_eq("mask_rd", v, 32'h8);
    idle(1'b1, 1'b1, 6);
    check_eq("irq_same_edge", 32'(bus.irq), 32'd0);
    idle(1'b1, 1'b1, 1);
    check_eq("irq_next_edge", 32'(bus.irq), 32'd1);
    tick(1'b1, 1'b1, BASE, 32'h8, 1'b1);
    idle(1'b1, 1'b1, 1);
    check_eq("irq_after_w1c", 32'(bus.irq), 32'd0);

    // reset while the right channel is mid-qualification
    idle(1'b0, 1'b0, 6);
    idle(1'b1, 1'b0, 4);
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 12'(i), v);
      check_eq("midreset_reg", v, 32'd0);
    end
    check_eq("midreset_irq", 32'(bus.irq), 32'd0);
    idle(1'b1, 1'b0, 5);
    rd(BASE, v);
    check_eq("requal_not_yet", v, 32'd0);
    idle(1'b1, 1'b0, 1);
    rd(BASE, v);
    check_eq("requal_status", v, 32'h5);

    // randomized traffic against the model
    rr = 1'b1;
    ll = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) rr = ~rr;
      if ($urandom_range(0, 4) == 0) ll = ~ll;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0)
          tick(rr, ll, 12'($urandom_range(0, 12'hEFF)), $urandom, 1'b1);
        else
          tick(rr, ll, BASE + 12'($urandom_range(0, 3)), $urandom, 1'b1);
      end else begin
        tick(rr, ll, 12'($urandom), 32'd0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
